// File: rtl/aes_key_gen_if.sv
// Key-expansion stage bus: previous key, round number and enable in; registered next key and valid pulse out.
interface aes_key_gen_if;
  logic [127:0] pre_rnd_key;
  logic         i_en_key_gen;
  logic [3:0]   round_num;
  logic [127:0] next_rnd_key;
  logic         o_key_valid;

  modport master (
    output pre_rnd_key, i_en_key_gen, round_num,
    input  next_rnd_key, o_key_valid
  );

  modport slave (
    input  pre_rnd_key, i_en_key_gen, round_num,
    output next_rnd_key, o_key_valid
  );
endinterface

// File: rtl/aes_key_gen.sv
// Single-round AES-128 key expansion (RotWord, SubWord, Rcon, chained XORs); 1-cycle registered latency.
// No backpressure: every enabled edge registers a new key; o_key_valid pulses once per enabled edge.
module aes_key_gen (
  input logic          i_clk,
  input logic          i_rst_n,
  aes_key_gen_if.slave kg
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w, temp_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon;
  logic [127:0] key_d, key_q;
  logic         vld_d, vld_q;

  assign {w0, w1, w2, w3} = kg.pre_rnd_key;
  assign rot_w = {w3[23:0], w3[31:24]};
  assign sub_w = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]], SBOX[rot_w[15:8]], SBOX[rot_w[7:0]]};

  // Out-of-range rounds still produce a key, just with a zero round constant.
  always_comb begin
    rcon = 8'h00;
    case (kg.round_num)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign temp_w = sub_w ^ {rcon, 24'h000000};
  assign n0     = w0 ^ temp_w;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;
  assign key_d  = {n0, n1, n2, n3};
  assign vld_d  = kg.i_en_key_gen;

  // The key register only loads on enable, so inputs are don't-care while idle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      key_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (kg.i_en_key_gen) begin
        key_q <= key_d;
      end
    end
  end

  assign kg.next_rnd_key = key_q;
  assign kg.o_key_valid  = vld_q;

endmodule

// File: tb/tb_aes_key_gen.sv
// Directed FIPS-197 vectors plus a GF(2^8)-derived reference model for random and chained rounds.
module tb_aes_key_gen;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  aes_key_gen_if kg_if ();

  aes_key_gen u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .kg      (kg_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] pre;
    logic [3:0]   rnd;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  // S-box built from its definition: multiplicative inverse then the affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    for (int x = 1; x < 256; x++) begin
      if (gf_mul(b, 8'(x)) == 8'h01) inv = 8'(x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_ref(input logic [3:0] r);
    logic [7:0] c;
    if (r < 4'd1 || r > 4'd10) return 8'h00;
    c = 8'h01;
    for (int i = 1; i < int'(r); i++) c = xtime(c);
    return c;
  endfunction

  function automatic logic [127:0] key_ref(input logic [127:0] pre, input logic [3:0] r);
    logic [31:0] w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;
    w3 = pre[31:0];
    t  = {sbox_ref(w3[23:16]) ^ rcon_ref(r), sbox_ref(w3[15:8]),
          sbox_ref(w3[7:0]), sbox_ref(w3[31:24])};
    n0 = pre[127:96] ^ t;
    n1 = pre[95:64] ^ n0;
    n2 = pre[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [127:0] pre, input logic [3:0] rnd);
    @(negedge clk);
    kg_if.i_en_key_gen = en;
    kg_if.pre_rnd_key  = pre;
    kg_if.round_num    = rnd;
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [127:0] held;
  logic [127:0] pre;
  logic [127:0] exp;
  logic [3:0]   rnd;

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{"fips_r1",    128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[1] = '{"fips_r2",    128'ha0fafe1788542cb123a339392a6c7605, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[2] = '{"fips_r10",   128'hac7766f319fadc2128d12941575c006e, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[3] = '{"zero_r1",    128'h0,                                4'd1,  128'h62636363626363636263636362636363};
    vecs[4] = '{"zero_r0",    128'h0,                                4'd0,  128'h63636363636363636363636363636363};
    vecs[5] = '{"zero_r15",   128'h0,                                4'd15, 128'h63636363636363636363636363636363};

    // Reset held for two edges with enable high and random inputs.
    rst_n = 1'b0;
    kg_if.i_en_key_gen = 1'b1;
    kg_if.pre_rnd_key  = rand128();
    kg_if.round_num    = 4'($urandom_range(1, 10));
    sample();
    sample();
    check("rst_key", kg_if.next_rnd_key, 128'h0);
    check("rst_vld", {127'h0, kg_if.o_key_valid}, 128'h0);

    @(negedge clk);
    rst_n = 1'b1;
    kg_if.i_en_key_gen = 1'b0;
    sample();
    check("idle_key", kg_if.next_rnd_key, 128'h0);
    check("idle_vld", {127'h0, kg_if.o_key_valid}, 128'h0);

    // Directed table, with an idle cycle between entries so each valid is a single pulse.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].pre, vecs[i].rnd);
      sample();
      check({vecs[i].name, "_key"}, kg_if.next_rnd_key, vecs[i].exp);
      check({vecs[i].name, "_vld"}, {127'h0, kg_if.o_key_valid}, 128'h1);
      drive(1'b0, rand128(), 4'($urandom_range(0, 15)));
      sample();
      check({vecs[i].name, "_drop"}, {127'h0, kg_if.o_key_valid}, 128'h0);
    end

    // Hold: output frozen while idle, whatever the inputs do.
    drive(1'b1, vecs[0].pre, vecs[0].rnd);
    sample();
    held = kg_if.next_rnd_key;
    check("hold_load", held, vecs[0].exp);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, rand128(), 4'($urandom_range(0, 15)));
      sample();
      check("hold_key", kg_if.next_rnd_key, vecs[0].exp);
      check("hold_vld", {127'h0, kg_if.o_key_valid}, 128'h0);
    end

    // Back-to-back random rounds against the reference model.
    for (int i = 0; i < 12; i++) begin
      pre = rand128();
      rnd = 4'($urandom_range(1, 10));
      exp = key_ref(pre, rnd);
      drive(1'b1, pre, rnd);
      sample();
      check("rand_key", kg_if.next_rnd_key, exp);
      check("rand_vld", {127'h0, kg_if.o_key_valid}, 128'h1);
    end

    // Full schedule with the output fed back; last key is the FIPS-197 round 10 key.
    pre = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    for (int r = 1; r <= 10; r++) begin
      drive(1'b1, pre, 4'(r));
      sample();
      check("chain_step", kg_if.next_rnd_key, key_ref(pre, 4'(r)));
      pre = kg_if.next_rnd_key;
    end
    check("chain_r10", pre, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset mid-schedule wins over enable.
    @(negedge clk);
    rst_n = 1'b0;
    kg_if.i_en_key_gen = 1'b1;
    sample();
    check("midrst_key", kg_if.next_rnd_key, 128'h0);
    check("midrst_vld", {127'h0, kg_if.o_key_valid}, 128'h0);

    // Release with enable high on the same edge computes immediately.
    @(negedge clk);
    rst_n = 1'b1;
    kg_if.pre_rnd_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    kg_if.round_num   = 4'd1;
    sample();
    check("rel_en_key", kg_if.next_rnd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    check("rel_en_vld", {127'h0, kg_if.o_key_valid}, 128'h1);

    drive(1'b0, 128'h0, 4'd0);
    sample();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
